// File: rtl/dmem_sb_pkg.sv
// Shared types and constants for the data-memory store buffer.
package dmem_sb_pkg;

    localparam int unsigned SB_ADDR_W        = 32;
    localparam int unsigned SB_DATA_W        = 32;
    // Byte-offset bits ignored when matching loads against buffered stores
    localparam int unsigned WORD_OFFSET_BITS = 2;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FENCE = 2'd1,
        DONE  = 2'd2
    } sb_state_t;

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-match selector: finds the newest valid entry whose word address equals the load's.
module sb_fwd_match
    import dmem_sb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]   entry_data_i,
    input  logic [$clog2(DEPTH)-1:0]       rd_ptr_i,
    input  logic [$clog2(DEPTH+1)-1:0]     count_i,
    input  logic [ADDR_W-1:0]              ld_addr_i,
    output logic                           hit_c_o,
    output logic [DATA_W-1:0]              data_c_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] idx_c;
    logic             unused_offset_c;

    // Walk from oldest to youngest so the last match (the youngest) wins
    always_comb begin
        hit_c_o  = 1'b0;
        data_c_o = '0;
        idx_c    = rd_ptr_i;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx_c = rd_ptr_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) &&
                (entry_addr_i[idx_c][ADDR_W-1:WORD_OFFSET_BITS] ==
                 ld_addr_i[ADDR_W-1:WORD_OFFSET_BITS])) begin
                hit_c_o  = 1'b1;
                data_c_o = entry_data_i[idx_c];
            end
        end
    end

    // Byte-offset bits take no part in the match
    always_comb begin
        unused_offset_c = ^ld_addr_i[WORD_OFFSET_BITS-1:0];
        for (int unsigned k = 0; k < DEPTH; k++) begin
            unused_offset_c = unused_offset_c ^ (^entry_addr_i[k][WORD_OFFSET_BITS-1:0]);
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-store FIFO between the core's store port and data memory, with load forwarding and fence drain.
module dmem_store_buffer
    import dmem_sb_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W,
    parameter int unsigned DATA_W = SB_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    input  logic [ADDR_W-1:0]            st_addr,
    input  logic [DATA_W-1:0]            st_data,
    output logic                         st_ready,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         ld_hit,
    output logic [DATA_W-1:0]            ld_data,
    output logic                         mem_write,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_write_data,
    input  logic                         mem_ready,
    input  logic                         fence_req,
    output logic                         fence_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    sb_state_t                    state_q, state_d;
    logic                         push_c;
    logic                         pop_c;

    // Handshake qualifiers and head-of-queue presentation
    assign empty          = (count_q == '0);
    assign count          = count_q;
    assign st_ready       = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
    assign mem_write      = !empty;
    assign mem_addr       = addr_q[rd_ptr_q];
    assign mem_write_data = data_q[rd_ptr_q];
    assign fence_done     = (state_q == DONE);
    assign push_c         = st_valid && st_ready;
    assign pop_c          = mem_write && mem_ready;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Fence sequencing: block stores until drained, then pulse done for one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (fence_req) begin
                    state_d = empty ? DONE : FENCE;
                end
            end
            FENCE: begin
                if (empty) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= RUN;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates every use
    always_ff @(posedge clk) begin
        if (push_c && !reset) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
        end
    end

    sb_fwd_match #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .entry_addr_i (addr_q),
        .entry_data_i (data_q),
        .rd_ptr_i     (rd_ptr_q),
        .count_i      (count_q),
        .ld_addr_i    (ld_addr),
        .hit_c_o      (ld_hit),
        .data_c_o     (ld_data)
    );

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized + directed bench for dmem_store_buffer with a queue-based reference model and write scoreboard.
module tb_dmem_store_buffer;
    import dmem_sb_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH+1);
    localparam int M_RUN   = 0;
    localparam int M_FENCE = 1;
    localparam int M_DONE  = 2;

    logic          clk = 1'b0;
    logic          reset, st_valid, st_ready, ld_hit, mem_write, mem_ready;
    logic          fence_req, fence_done, empty;
    logic [31:0]   st_addr, st_data, ld_addr, ld_data, mem_addr, mem_write_data;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    dmem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .ld_addr        (ld_addr),
        .ld_hit         (ld_hit),
        .ld_data        (ld_data),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_ready      (mem_ready),
        .fence_req      (fence_req),
        .fence_done     (fence_done),
        .count          (count),
        .empty          (empty)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: buffered stores in program order, plus the fence phase
    sb_entry_t model_q[$];
    sb_entry_t exp_q[$];
    int        mstate = M_RUN;

    initial forever begin
        int        sz;
        bit        acc, drn;
        sb_entry_t e;
        @(posedge clk);
        sz = model_q.size();
        if (reset) begin
            model_q.delete();
            exp_q.delete();
            mstate = M_RUN;
        end else begin
            acc = st_valid && (sz < DEPTH) && (mstate == M_RUN);
            drn = (sz != 0) && mem_ready;
            case (mstate)
                M_RUN:   if (fence_req) mstate = (sz == 0) ? M_DONE : M_FENCE;
                M_FENCE: if (sz == 0) mstate = M_DONE;
                default: mstate = M_RUN;
            endcase
            if (drn) void'(model_q.pop_front());
            if (acc) begin
                e.addr = st_addr;
                e.data = st_data;
                model_q.push_back(e);
                exp_q.push_back(e);
            end
        end
    end

    // Per-cycle status and forwarding checks against the model
    initial begin
        wait (started);
        forever begin
            int          sz;
            bit          eh;
            logic [31:0] ed;
            logic [29:0] lw;
            logic [29:0] ew;
            @(negedge clk);
            sz = model_q.size();
            chk("st_ready",   64'(st_ready),   64'((sz < DEPTH) && (mstate == M_RUN)));
            chk("mem_write",  64'(mem_write),  64'(sz != 0));
            chk("count",      64'(count),      64'(sz));
            chk("empty",      64'(empty),      64'(sz == 0));
            chk("fence_done", 64'(fence_done), 64'(mstate == M_DONE));
            eh = 1'b0;
            ed = '0;
            lw = ld_addr[31:2];
            for (int i = sz - 1; i >= 0; i--) begin
                ew = model_q[i].addr[31:2];
                if (!eh && ew == lw) begin
                    eh = 1'b1;
                    ed = model_q[i].data;
                end
            end
            chk("ld_hit", 64'(ld_hit), 64'(eh));
            if (eh) chk("ld_data", 64'(ld_data), 64'(ed));
        end
    end

    // Scoreboard monitor: every accepted memory write must be the next expected store
    initial begin
        wait (started);
        forever begin
            sb_entry_t e;
            @(negedge clk);
            if (!reset && mem_write && mem_ready) begin
                chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_mem_addr", 64'(mem_addr),       64'(e.addr));
                    chk("sb_mem_data", 64'(mem_write_data), 64'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        st_valid  = 1'b0;
        fence_req = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
    endtask

    initial begin
        int g;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = '0; mem_ready = 1'b0; fence_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        started = 1'b1;
        chk("rst_count",      64'(count),      64'(0));
        chk("rst_st_ready",   64'(st_ready),   64'(1));
        chk("rst_mem_write",  64'(mem_write),  64'(0));
        chk("rst_fence_done", 64'(fence_done), 64'(0));
        chk("rst_ld_hit",     64'(ld_hit),     64'(0));
        tick();

        // Ordering, one-cycle latency
        mem_ready = 1'b1;
        put(32'd96, 32'd7);
        chk("t1_first_addr", 64'(mem_addr), 64'(96));
        chk("t1_first_data", 64'(mem_write_data), 64'(7));
        put(32'd100, 32'd25);
        chk("t1_second_addr", 64'(mem_addr), 64'(100));
        chk("t1_second_data", 64'(mem_write_data), 64'(25));
        idle();
        tick();
        chk("t1_empty", 64'(empty), 64'(1));
        tick();

        // Full and backpressure
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) put(32'd200 + 32'(i) * 4, 32'h1000 + 32'(i));
        chk("t2_full_count", 64'(count), 64'(4));
        chk("t2_full_ready", 64'(st_ready), 64'(0));
        st_valid = 1'b1; st_addr = 32'd216; st_data = 32'h1004;
        tick(); tick(); tick();
        mem_ready = 1'b1;
        g = 0;
        while (!st_ready && g < 10) begin tick(); g++; end
        chk("t2_push_wait", 64'(st_ready), 64'(1));
        tick();
        idle();
        repeat (8) tick();
        chk("t2_drained", 64'(empty), 64'(1));

        // Forwarding youngest match
        mem_ready = 1'b0;
        put(32'd100, 32'd3);
        put(32'd100, 32'd25);
        idle();
        ld_addr = 32'd102;
        #1;
        chk("t3_fwd_hit",  64'(ld_hit),  64'(1));
        chk("t3_fwd_data", 64'(ld_data), 64'(25));
        ld_addr = 32'd104;
        #1;
        chk("t3_fwd_miss", 64'(ld_hit), 64'(0));
        mem_ready = 1'b1;
        repeat (4) tick();

        // Simultaneous push and pop across the pointer wrap
        mem_ready = 1'b0;
        put(32'h300, 32'hA0);
        put(32'h304, 32'hA1);
        chk("t4_count_pre", 64'(count), 64'(2));
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) put(32'h308 + 32'(i) * 4, 32'hB0 + 32'(i));
        chk("t4_count_post", 64'(count), 64'(2));
        idle();
        repeat (4) tick();

        // Fence with toggling memory ready, then fence on an empty buffer
        mem_ready = 1'b0;
        put(32'h400, 32'hC0);
        put(32'h404, 32'hC1);
        put(32'h408, 32'hC2);
        st_valid = 1'b0;
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        st_valid = 1'b1; st_addr = 32'h500; st_data = 32'hD0;
        chk("t5_fence_blocks", 64'(st_ready), 64'(0));
        for (int i = 0; i < 14; i++) begin
            mem_ready = (i % 2 == 1);
            tick();
        end
        idle();
        mem_ready = 1'b1;
        repeat (4) tick();
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        chk("t5_empty_fence_done", 64'(fence_done), 64'(1));
        tick();
        chk("t5_done_once", 64'(fence_done), 64'(0));
        chk("t5_ready_back", 64'(st_ready), 64'(1));

        // Reset mid-drain
        mem_ready = 1'b0;
        put(32'h600, 32'hE0);
        put(32'h604, 32'hE1);
        put(32'h608, 32'hE2);
        st_valid = 1'b0;
        mem_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_count",      64'(count),      64'(0));
        chk("t6_mem_write",  64'(mem_write),  64'(0));
        chk("t6_fence_done", 64'(fence_done), 64'(0));
        put(32'h700, 32'hABC);
        idle();
        chk("t6_after_addr", 64'(mem_addr), 64'(32'h700));
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            st_valid  = ($urandom_range(0, 1) == 1);
            st_addr   = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            st_data   = $urandom;
            ld_addr   = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
            mem_ready = ($urandom_range(0, 9) < 6);
            fence_req = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle();
        mem_ready = 1'b1;
        repeat (12) tick();
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
- Posted-store FIFO between the core's data-memory write port (dmem_addr / dmem_write_data / dmem_write) and the data memory.
- Lets the pipeline retire stores without waiting on memory.
- Drains stores to memory in program order, one per accepted cycle.
- Forwards the youngest buffered store to loads that hit the same word address, so loads never return stale memory data.

Parameters:
- DEPTH, 4, number of store entries; must be a power of 2 and at least 2.
- ADDR_W, 32, address width.
- DATA_W, 32, store and load data width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset. Sampled on posedge clk. Clears all state.
- st_valid  in  1  core presents a store this cycle.
- st_addr  in  ADDR_W  store byte address.
- st_data  in  DATA_W  store data.
- st_ready  out  1  buffer accepts a store this cycle.
- ld_addr  in  ADDR_W  address of the load in the memory stage.
- ld_hit  out  1  a buffered store matches ld_addr.
- ld_data  out  DATA_W  forwarded data; valid only when ld_hit=1.
- mem_write  out  1  head entry presented to memory.
- mem_addr  out  ADDR_W  head entry address.
- mem_write_data  out  DATA_W  head entry data.
- mem_ready  in  1  memory accepts the presented write this cycle.
- fence_req  in  1  one-cycle pulse requesting a full drain (FENCE instruction or end-of-test).
- fence_done  out  1  one-cycle pulse when the drain requested by fence_req completes.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.

Behaviour:
- Storage and pointers:
  - Circular array of DEPTH entries {addr, data}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is kept as a separate register.
- Reset: count=0, wr_ptr=0, rd_ptr=0, state=RUN. Resulting outputs: mem_write=0, fence_done=0, ld_hit=0, empty=1, st_ready=1.
  - Reset asserted mid-drain discards all entries.
  - A write that was presented in the reset cycle is dropped.
- Push: occurs when st_valid && st_ready.
  - st_ready = (count<DEPTH) && state==RUN.
  - There is no push-through when full, even if a pop occurs in the same cycle.
- Drain:
  - mem_write = !empty. mem_addr and mem_write_data come combinationally from entry[rd_ptr].
  - Pop when mem_write && mem_ready.
  - mem_addr/mem_write_data must hold stable while mem_write=1 and mem_ready=0.
- Latency: a store pushed in cycle N is first presented to memory in cycle N+1, at the earliest. There is no empty-bypass.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Ordering:
  - Strict FIFO.
  - No coalescing: two stores to the same address occupy two entries and are both written.
- Forwarding (combinational):
  - Match = entry valid && entry.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]. Bits [1:0] are ignored.
  - With multiple matches, the youngest entry (closest to wr_ptr) wins.
  - An entry popping this cycle still forwards.
  - A store being pushed this cycle does not forward; the pipeline handles that case.
- FSM states:
  - RUN: fence_req && empty → DONE. fence_req && !empty → FENCE.
  - FENCE: st_ready=0. Moves to DONE in the cycle after count reaches 0.
  - DONE: fence_done=1 for exactly one cycle; st_ready=0. Always → RUN.
  - fence_req while in FENCE or DONE is ignored.
- Width rules:
  - Addresses and data pass through unmodified.
  - count width is sized so that count==DEPTH is representable.

Decomposition:
- Package dmem_sb_pkg:
  - typedef sb_entry_t {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}
  - enum sb_state_t {RUN, FENCE, DONE}
  - constant WORD_OFFSET_BITS=2.
- One natural sub-module: sb_fwd_match. This is the combinational youngest-match priority selector over DEPTH entries, given rd_ptr and count.
- FIFO pointers and the FSM stay in the top-level module.

Test Plan:
1. Ordering: with mem_ready=1, push (96, 7) then (100, 25) in back-to-back cycles → memory sees addr 96/data 7, then 100/25 on consecutive cycles, each one cycle after its push; empty=1 afterwards.
2. Full/backpressure: mem_ready=0, push 5 stores at DEPTH=4 → st_ready drops after the 4th and count=4. Set mem_ready=1 → exactly 4 writes in FIFO order and no lost or duplicated entry. The 5th store is accepted only after count<4.
3. Forwarding: buffer (100, 3) then (100, 25), with mem_ready=0, and ld_addr=102 → ld_hit=1 and ld_data=25. ld_addr=104 → ld_hit=0.
4. Simultaneous push/pop at count=2 → count stays 2 and both pointers advance. Repeat across the wrap boundary (wr_ptr 3→0) → no corruption.
5. Fence: 3 entries buffered, pulse fence_req, mem_ready toggling → st_ready=0 until drain completes. fence_done pulses once, one cycle after count hits 0, then st_ready=1. fence_req with the buffer already empty → fence_done on the next cycle.
6. Reset mid-drain: count=3, assert reset for one cycle → next cycle count=0, mem_write=0, fence_done=0. The first store after reset appears at memory one cycle after its push.
